// File: rtl/serial_shl_unit.sv
// serial_shl_unit: multi-cycle logical shift-left engine with valid/ready on
// both sides. It shifts STEP bits per BUSY cycle and handles one operation at
// a time. The result matches (I0 << I1) truncated to width, and any shift
// amount >= width yields zero.
module serial_shl_unit #(
    parameter int width = 8,
    parameter int STEP  = 1
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [width-1:0] I0,
    input  logic [width-1:0] I1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] O,
    output logic             out_valid,
    input  logic             out_ready
);

    // rem only ever holds a shift amount below width.
    localparam int RW = $clog2(width) + 1;
    // Wide enough to compare the whole I1 against width without truncating either side.
    localparam int CW = (width > 32) ? width : 32;
    localparam logic [RW-1:0] STEP_R = RW'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [width-1:0] res;
    logic [RW-1:0]   rem;
    logic [RW-1:0]   shamt;
    logic [RW-1:0]   rem_next;
    logic            accept;
    logic            zero_shift;
    logic            over_shift;

    // The final BUSY cycle may shift fewer than STEP bits.
    function automatic logic [RW-1:0] step_amount(input logic [RW-1:0] left);
        return (left < STEP_R) ? left : STEP_R;
    endfunction

    // Per-cycle shift amount, remaining count and accept-path decode.
    always_comb begin
        shamt      = step_amount(rem);
        rem_next   = rem - shamt;
        accept     = (state == IDLE) && in_valid;
        zero_shift = (I1 == '0);
        over_shift = (CW'(I1) >= CW'(width));
    end

    // Outputs come only from registered state, so no input reaches an output combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign O         = res;

    // Control FSM and shift datapath. Reset aborts any operation in flight.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state <= IDLE;
            res   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (zero_shift) begin
                            res   <= I0;
                            rem   <= '0;
                            state <= DONE;
                        end else if (over_shift) begin
                            res   <= '0;
                            rem   <= '0;
                            state <= DONE;
                        end else begin
                            // I1 < width here, so it fits in rem.
                            res   <= I0;
                            rem   <= RW'(I1);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    res <= res << shamt;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // res is left unchanged, so O still shows the last result in IDLE.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
